// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter_if                                                |
// | Brief    : Fetch, data and memory-side bus bundle for mem_arbiter.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          m_ren;
   logic          m_wen;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata;

   // Arbiter side
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output i_rdata, i_ack, d_rdata, d_ack, m_ren, m_wen, m_addr, m_wdata
   );

   // Requester / memory side
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  i_rdata, i_ack, d_rdata, d_ack, m_ren, m_wen, m_addr, m_wdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_arbiter                                                   |
// | Brief    : Two-port (fetch/data) arbiter onto one memory, D-priority     |
// |            with a fetch starvation guard. MEMARB_PERF_EN adds counters.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  wire logic      clock,
   input  wire logic      reset,
   mem_arbiter_if.slave   bus,
   output logic           conflict
`ifdef MEMARB_PERF_EN
   ,
   output logic [31:0]    perf_i_cnt,
   output logic [31:0]    perf_d_cnt,
   output logic [31:0]    perf_conf_cnt
`endif
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam logic [2:0] c_lat_init = 3'(MEM_LAT);
   localparam logic       c_own_i    = 1'b0;
   localparam logic       c_own_d    = 1'b1;

   state_t        r_state;
   logic          r_owner;
   logic [2:0]    r_lat;
   logic          r_we;
   logic [1:0]    r_d_streak;
   logic          r_i_ack;
   logic          r_d_ack;
   logic [DW-1:0] r_i_rdata;
   logic [DW-1:0] r_d_rdata;

   logic          w_idle;
   logic          w_i_elig;
   logic          w_d_elig;
   logic          w_grant_i;
   logic          w_grant_d;
   logic          w_conflict;
   logic [AW-1:0] w_m_addr;
   logic [DW-1:0] w_m_wdata;

   // A port is ineligible in its own ack cycle so it is never re-granted there
   always_comb begin
      w_idle     = (r_state == S_IDLE);
      w_i_elig   = w_idle & bus.i_req & ~r_i_ack;
      w_d_elig   = w_idle & bus.d_req & ~r_d_ack;
      w_grant_i  = w_i_elig & (~w_d_elig | (r_d_streak == 2'd2));
      w_grant_d  = w_d_elig & ~w_grant_i;
      w_conflict = w_i_elig & w_d_elig;
      w_m_addr   = '0;
      w_m_wdata  = '0;
      if (w_grant_i) begin
         w_m_addr = bus.i_addr;
      end else if (w_grant_d) begin
         w_m_addr  = bus.d_addr;
         w_m_wdata = bus.d_wdata;
      end
   end

   assign bus.m_ren   = w_grant_i | (w_grant_d & ~bus.d_we);
   assign bus.m_wen   = w_grant_d & bus.d_we;
   assign bus.m_addr  = w_m_addr;
   assign bus.m_wdata = w_m_wdata;
   assign bus.i_ack   = r_i_ack;
   assign bus.d_ack   = r_d_ack;
   assign bus.i_rdata = r_i_rdata;
   assign bus.d_rdata = r_d_rdata;
   assign conflict    = w_conflict;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_owner       <= c_own_i;
         r_lat         <= 3'd0;
         r_we          <= 1'b0;
         r_d_streak    <= 2'd0;
         r_i_ack       <= 1'b0;
         r_d_ack       <= 1'b0;
         r_i_rdata     <= '0;
         r_d_rdata     <= '0;
`ifdef MEMARB_PERF_EN
         perf_i_cnt    <= 32'd0;
         perf_d_cnt    <= 32'd0;
         perf_conf_cnt <= 32'd0;
`endif
      end else begin
         r_i_ack <= 1'b0;
         r_d_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_i) begin
                  r_owner    <= c_own_i;
                  r_we       <= 1'b0;
                  r_lat      <= c_lat_init;
                  r_d_streak <= 2'd0;
                  r_state    <= S_WAIT;
               end else if (w_grant_d) begin
                  r_owner <= c_own_d;
                  r_we    <= bus.d_we;
                  r_lat   <= c_lat_init;
                  r_state <= S_WAIT;
                  if (bus.i_req && (r_d_streak != 2'd2)) begin
                     r_d_streak <= r_d_streak + 2'd1;
                  end
               end
            end
            S_WAIT: begin
               r_lat <= r_lat - 3'd1;
               if (r_lat == 3'd1) begin
                  r_state <= S_IDLE;
                  if (r_owner == c_own_d) begin
                     r_d_ack <= 1'b1;
                     if (!r_we) begin
                        r_d_rdata <= bus.m_rdata;
                     end
                  end else begin
                     r_i_ack   <= 1'b1;
                     r_i_rdata <= bus.m_rdata;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef MEMARB_PERF_EN
         if (w_grant_i)  perf_i_cnt    <= perf_i_cnt + 32'd1;
         if (w_grant_d)  perf_d_cnt    <= perf_d_cnt + 32'd1;
         if (w_conflict) perf_conf_cnt <= perf_conf_cnt + 32'd1;
`endif
      end
   end

endmodule
`default_nettype wire
